// File: rtl/sync_mod_counter.sv
// Synchronous modulo-MOD up/down counter with parallel load, wrap or
// saturate behaviour at the terminal value, and terminal-count/wrap/sat status.
// Every state bit updates on posedge clk, so there is no ripple between bits.
module sync_mod_counter #(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MOD      = 16,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    // The top value always fits in WIDTH bits, even when MOD == 2**WIDTH.
    localparam logic [WIDTH-1:0] TOP  = WIDTH'(MOD - 64'd1);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_sat;

    logic [WIDTH-1:0] w_term;
    logic             w_tc;
    logic [WIDTH-1:0] w_load_clamped;
    logic             w_load_is_term;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_wrap_nxt;
    logic             w_sat_nxt;

    // Terminal value depends only on direction; tc is the sole combinational output.
    always_comb begin
        w_term         = up_dn ? TOP : ZERO;
        w_tc           = (r_count == w_term);
        w_load_clamped = (load_val > TOP) ? TOP : load_val;
        w_load_is_term = (w_load_clamped == w_term);
    end

    // Next-state selection: rst > load > en > hold.
    always_comb begin
        w_count_nxt = r_count;
        w_wrap_nxt  = 1'b0;
        w_sat_nxt   = r_sat;
        if (rst) begin
            w_count_nxt = ZERO;
            w_sat_nxt   = 1'b0;
        end else if (load) begin
            w_count_nxt = w_load_clamped;
            w_sat_nxt   = SATURATE && w_load_is_term;
        end else if (en) begin
            if (w_tc) begin
                if (SATURATE) begin
                    w_sat_nxt = 1'b1;
                end else begin
                    // Explicit wrap target keeps MOD < 2**WIDTH correct and
                    // never needs a carry bit when MOD == 2**WIDTH.
                    w_count_nxt = up_dn ? ZERO : TOP;
                    w_wrap_nxt  = 1'b1;
                    w_sat_nxt   = 1'b0;
                end
            end else begin
                w_count_nxt = up_dn ? (r_count + ONE) : (r_count - ONE);
                w_sat_nxt   = 1'b0;
            end
        end
    end

    // Register count and status flags.
    always_ff @(posedge clk) begin
        r_count <= w_count_nxt;
        r_wrap  <= w_wrap_nxt;
        r_sat   <= w_sat_nxt;
    end

    assign count = r_count;
    assign tc    = w_tc;
    assign wrap  = r_wrap;
    assign sat   = r_sat;

endmodule

// File: tb/tb_sync_mod_counter.sv
// Scoreboard bench for sync_mod_counter: three instances share one stimulus
// stream (wrap at 10, saturate at 10, wrap at 16).
module tb_sync_mod_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] c0, c1, c2;
    logic [2:0] tc_v, wrap_v, sat_v;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int idx;
        int cnt;
        int wr;
        int st;
    } exp_t;

    exp_t sb_q[$];

    int m_cnt [3];
    int m_wrap[3];
    int m_sat [3];
    int m_mod [3] = '{10, 10, 16};
    int m_satm[3] = '{0, 1, 0};

    always #5 clk = ~clk;

    sync_mod_counter #(.WIDTH(4), .MOD(10), .SATURATE(1'b0)) u_d0 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .count(c0), .tc(tc_v[0]), .wrap(wrap_v[0]), .sat(sat_v[0]));
    sync_mod_counter #(.WIDTH(4), .MOD(10), .SATURATE(1'b1)) u_d1 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .count(c1), .tc(tc_v[1]), .wrap(wrap_v[1]), .sat(sat_v[1]));
    sync_mod_counter #(.WIDTH(4), .MOD(16), .SATURATE(1'b0)) u_d2 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .count(c2), .tc(tc_v[2]), .wrap(wrap_v[2]), .sat(sat_v[2]));

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    endtask

    function automatic int get_cnt(input int i);
        logic [3:0] v;
        v = (i == 0) ? c0 : (i == 1) ? c1 : c2;
        if ($isunknown(v)) return -1;
        return int'(v);
    endfunction

    // Reference behaviour of one instance for one clock edge.
    task automatic model_step(input int i, input bit r, input bit ld, input int lv,
                              input bit e, input bit ud);
        int term;
        int v;
        term = ud ? m_mod[i] - 1 : 0;
        if (r) begin
            m_cnt[i] = 0; m_wrap[i] = 0; m_sat[i] = 0;
        end else if (ld) begin
            v = (lv > m_mod[i] - 1) ? m_mod[i] - 1 : lv;
            m_cnt[i]  = v;
            m_wrap[i] = 0;
            m_sat[i]  = (m_satm[i] != 0 && v == term) ? 1 : 0;
        end else if (e) begin
            if (m_cnt[i] == term) begin
                if (m_satm[i] != 0) begin
                    m_sat[i] = 1; m_wrap[i] = 0;
                end else begin
                    m_cnt[i]  = ud ? 0 : m_mod[i] - 1;
                    m_wrap[i] = 1; m_sat[i] = 0;
                end
            end else begin
                m_cnt[i]  = (m_cnt[i] + (ud ? 1 : -1) + m_mod[i]) % m_mod[i];
                m_wrap[i] = 0; m_sat[i] = 0;
            end
        end else begin
            m_wrap[i] = 0;
        end
    endtask

    // Drive one cycle of stimulus, check tc against the pre-edge state,
    // queue post-edge expectations, then pop and compare after the edge.
    task automatic cyc(input bit r, input bit ld, input int lv, input bit e, input bit ud,
                       input bit check_tc);
        exp_t x;
        @(negedge clk);
        rst = r; load = ld; load_val = 4'(lv); en = e; up_dn = ud;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (check_tc)
                chk($sformatf("d%0d tc", i), int'(tc_v[i]),
                    (m_cnt[i] == (ud ? m_mod[i] - 1 : 0)) ? 1 : 0);
            model_step(i, r, ld, lv, e, ud);
            x.idx = i; x.cnt = m_cnt[i]; x.wr = m_wrap[i]; x.st = m_sat[i];
            sb_q.push_back(x);
        end
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            chk($sformatf("d%0d count", x.idx), get_cnt(x.idx), x.cnt);
            chk($sformatf("d%0d wrap", x.idx), int'(wrap_v[x.idx]), x.wr);
            chk($sformatf("d%0d sat", x.idx), int'(sat_v[x.idx]), x.st);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_wrap[i] = 0; m_sat[i] = 0;
        end
        // Reset, then tc reflects count=0 when counting down.
        cyc(1, 0, 0, 0, 1, 0);
        @(negedge clk);
        up_dn = 1'b0;
        #1;
        chk("reset tc down", int'(tc_v[0]), 1);
        chk("reset count", get_cnt(0), 0);
        // Up count through a wrap.
        for (int k = 0; k < 12; k++) cyc(0, 0, 0, 1, 1, 1);
        // Load 2, then count down through 0.
        cyc(0, 1, 2, 0, 0, 1);
        for (int k = 0; k < 5; k++) cyc(0, 0, 0, 1, 0, 1);
        // Saturate from 7, then reverse direction.
        cyc(0, 1, 7, 0, 1, 1);
        for (int k = 0; k < 5; k++) cyc(0, 0, 0, 1, 1, 1);
        chk("sat held at 9", get_cnt(1), 9);
        cyc(0, 0, 0, 1, 0, 1);
        chk("sat reversed to 8", get_cnt(1), 8);
        // Load clamp with en high, then reset overriding load.
        cyc(0, 1, 13, 1, 1, 1);
        chk("clamp d0", get_cnt(0), 9);
        chk("no clamp d2", get_cnt(2), 13);
        cyc(1, 1, 6, 1, 1, 1);
        // Enable toggling across the full 16-value range.
        for (int k = 0; k < 40; k++) cyc(0, 0, 0, (k % 2 == 0), 1, 1);
        // Mid-count reversal at 5.
        cyc(0, 1, 5, 0, 1, 1);
        cyc(0, 0, 0, 1, 0, 1);
        chk("reverse to 4", get_cnt(0), 4);
        // Random mix.
        for (int k = 0; k < 300; k++)
            cyc(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
                int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sync_mod_counter.md
Name: sync_mod_counter

Overview:
Parametrised, fully synchronous modulo-N up/down counter. It is the next-generation replacement for the 4-bit negedge ripple counter. All state bits update on a single clock edge, so there are no ripple glitches. Adds synchronous reset, enable, direction, parallel load, wrap-or-saturate mode and terminal-count/wrap status. Intended for timers, dividers and sequencers in the lab designs.

Parameters:
WIDTH, 4, counter width in bits; 1 <= WIDTH <= 32
MOD, 16, modulus; count range is 0..MOD-1; 2 <= MOD <= 2**WIDTH
SATURATE, 0, 0 = wrap at the terminal value; 1 = hold at the terminal value

Ports:
clk  input  1  single clock; all state updates on posedge clk
rst  input  1  synchronous, active-high reset
en  input  1  count enable; when low, count holds
up_dn  input  1  direction; 1 = increment, 0 = decrement
load  input  1  synchronous parallel load request
load_val  input  WIDTH  value loaded when load=1
count  output  WIDTH  registered counter value
tc  output  1  terminal count, combinational from count and up_dn
wrap  output  1  registered one-cycle pulse after a wrap (SATURATE=0 only)
sat  output  1  registered; high while held at a terminal value (SATURATE=1 only)

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high. No asynchronous paths and no derived clocks; no logic is clocked by count bits.
- Reset: on posedge clk with rst=1: count=0, wrap=0, sat=0. tc then reflects count=0 (tc=1 if up_dn=0).
- Priority per edge: rst > load > en. Otherwise hold.
- Load: count <= load_val if load_val <= MOD-1, else count <= MOD-1 (clamp).
  - wrap <= 0 on a load edge.
  - sat <= 1 only if SATURATE=1 and the loaded value is terminal for the current up_dn; else 0.
  - load works regardless of en.
- Count, en=1:
  - up: count <= count+1 when count < MOD-1.
  - down: count <= count-1 when count > 0.
  - Arithmetic is WIDTH bits wide. MOD = 2**WIDTH must wrap naturally with no overflow bit.
- Terminal value: MOD-1 when up_dn=1; 0 when up_dn=0. tc = (count == terminal), independent of en.
- At terminal with en=1 and SATURATE=0:
  - up: count <= 0; down: count <= MOD-1.
  - wrap <= 1 for exactly one cycle.
- At terminal with en=1 and SATURATE=1:
  - count holds and sat <= 1.
  - sat clears on the first edge where count moves, load writes a non-terminal value, or rst.
  - Reversing up_dn at the terminal lets counting resume next edge.
- wrap is 0 in every cycle not immediately following a wrap edge. en=0 forces wrap <= 0.
- Direction change mid-count takes effect on the same edge the new up_dn is sampled.
- Reset mid-operation (during load or wrap) overrides everything; the next cycle shows reset values.
- Outputs count, wrap and sat are registered; tc is the only combinational output.
- Latency: one clk from input change to count update.

Test Plan:
- Reset then up count (WIDTH=4, MOD=10, SATURATE=0): rst for 1 cycle, then en=1, up_dn=1 for 12 cycles -> count 0,1,…,9,0,1. tc=1 when count=9. wrap=1 only in the cycle where count=0 after 9.
- Down wrap (MOD=10): load load_val=2, then en=1, up_dn=0 -> count 2,1,0,9,8. tc=1 at 0. wrap pulses once with count=9.
- Saturate (MOD=10, SATURATE=1): up from 7 for 5 cycles -> 8,9,9,9,9, sat=1 from the first held cycle. Then up_dn=0 -> 8 next edge, sat=0.
- Load clamp and priority: load=1, load_val=13, en=1 (MOD=10) -> count=9. Assert rst with load=1 -> count=0, wrap=0, sat=0.
- Enable hold and full range (WIDTH=4, MOD=16): en toggled 1/0 alternately -> count advances only on en=1 edges. 15 -> 0 wraps with wrap=1, with no X or overflow.
- Mid-count reversal: count=5, up_dn 1->0 on one edge -> next value 4, tc stays 0.
